regfile_wb_ctrl: RTL and testbench

- Writeback controller that owns the register file's single write port (we/waddr/wdata).
- Merges results from the load/store (MEM) path and the ALU path through a small in-order queue and emits at most one register write per cycle.
- Provides two pending-write lookup ports so decode can stall on RAW hazards against results not yet written.

---
 rtl/regfile_wb_ctrl_if.sv | 43 ++++
 rtl/regfile_wb_ctrl.sv | 97 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - result inputs, register write port and hazard lookup bundle
interface regfile_wb_ctrl_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_waddr;
   logic [DATA_W-1:0] alu_wdata;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] chk_addr1;
   logic              chk_hit1;
   logic [ADDR_W-1:0] chk_addr2;
   logic              chk_hit2;
   logic [CNT_W-1:0]  count;

   modport master (
      output mem_valid, mem_waddr, mem_wdata,
      output alu_valid, alu_waddr, alu_wdata,
      output chk_addr1, chk_addr2,
      input  mem_ready, alu_ready,
      input  we, waddr, wdata,
      input  chk_hit1, chk_hit2, count
   );

   modport slave (
      input  mem_valid, mem_waddr, mem_wdata,
      input  alu_valid, alu_waddr, alu_wdata,
      input  chk_addr1, chk_addr2,
      output mem_ready, alu_ready,
      output we, waddr, wdata,
      output chk_hit1, chk_hit2, count
   );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - in-order writeback queue owning the register file write port
// MEM and ALU results enter an in-order queue; one entry retires per cycle with RAW lookups.
module regfile_wb_ctrl #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   regfile_wb_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  alu_slot;
   logic [PTR_W-1:0]  offs [DEPTH];
   logic [DEPTH-1:0]  live;
   logic [CNT_W-1:0]  count_nxt;
   logic              mem_st;
   logic              alu_st;
   logic              pop;
   logic              hit1_q;
   logic              hit2_q;

   // Readies look only at the registered count so the pop path never feeds back into them.
   assign bus.mem_ready = rdy && (bus.count < CNT_W'(DEPTH));
   assign bus.alu_ready = rdy && ((bus.count < CNT_W'(DEPTH - 1)) ||
                                  ((bus.count < CNT_W'(DEPTH)) && !bus.mem_valid));

   // Writes to x0 complete the handshake but never occupy a slot.
   assign mem_st    = bus.mem_valid && bus.mem_ready && (bus.mem_waddr != '0);
   assign alu_st    = bus.alu_valid && bus.alu_ready && (bus.alu_waddr != '0);
   assign pop       = rdy && (bus.count != '0);
   assign alu_slot  = tail + PTR_W'(mem_st);
   assign count_nxt = bus.count + CNT_W'(mem_st) + CNT_W'(alu_st) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         bus.count <= '0;
         bus.we    <= 1'b0;
         bus.waddr <= '0;
         bus.wdata <= '0;
      end else if (rdy) begin
         bus.count <= count_nxt;
         tail      <= tail + PTR_W'(mem_st) + PTR_W'(alu_st);
         if (pop) begin
            bus.we    <= 1'b1;
            bus.waddr <= q_addr[head];
            bus.wdata <= q_data[head];
            head      <= head + PTR_W'(1);
         end else begin
            bus.we <= 1'b0;
         end
      end
   end

   // MEM is the older instruction, so it always takes the lower slot.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (mem_st) begin
            q_addr[tail] <= bus.mem_waddr;
            q_data[tail] <= bus.mem_wdata;
         end
         if (alu_st) begin
            q_addr[alu_slot] <= bus.alu_waddr;
            q_data[alu_slot] <= bus.alu_wdata;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         offs[i] = PTR_W'(i) - head;
         live[i] = ({1'b0, offs[i]} < bus.count);
      end
   end

   // A slot is pending when its distance from head is below count; the port register also counts.
   always_comb begin
      hit1_q = bus.we && (bus.waddr == bus.chk_addr1);
      hit2_q = bus.we && (bus.waddr == bus.chk_addr2);
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && (q_addr[i] == bus.chk_addr1)) hit1_q = 1'b1;
         if (live[i] && (q_addr[i] == bus.chk_addr2)) hit2_q = 1'b1;
      end
   end

   assign bus.chk_hit1 = hit1_q && (bus.chk_addr1 != '0);
   assign bus.chk_hit2 = hit2_q && (bus.chk_addr2 != '0);
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed vector and sequence bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
   typedef struct {
      logic        rdy;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        mr;
      logic        ar;
      logic        h1;
      logic        h2;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [2:0]  cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy = 1'b0;
   int   total = 0;
   int   passed = 0;
   int   x0_writes = 0;
   int   writes = 0;
   logic [36:0] sb[$];
   vec_t vt[14];

   always #5 clk = ~clk;

   regfile_wb_ctrl_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) b4 ();
   regfile_wb_ctrl_if #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) b2 ();

   regfile_wb_ctrl #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) u_dut (
      .clk(clk), .rst(rst), .rdy(rdy), .bus(b4)
   );
   regfile_wb_ctrl #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) u_dut2 (
      .clk(clk), .rst(rst), .rdy(rdy), .bus(b2)
   );

   always @(negedge clk) if (b4.we && b4.waddr == 5'd0) x0_writes++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
      b4.mem_valid = mv; b4.mem_waddr = ma; b4.mem_wdata = md;
      b4.alu_valid = av; b4.alu_waddr = aa; b4.alu_wdata = ad;
   endtask

   task automatic port_write();
      logic [36:0] e;
      writes++;
      if (sb.size() == 0) begin
         chk("fill_extra_write", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("fill_waddr", 32'(b4.waddr), 32'(e[36:32]));
         chk("fill_wdata", b4.wdata, e[31:0]);
      end
   endtask

   initial begin
      int exp_ar[6];
      int exp_cnt[6];
      bit m_acc, a_acc;

      exp_ar  = '{1, 1, 0, 0, 0, 0};
      exp_cnt = '{2, 3, 3, 3, 3, 3};
      // rdy mv ma md av aa ad c1 c2 | mr ar h1 h2 | we wa wd cnt
      vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      vt[1]  = '{1, 0, 0, 0, 1, 5, 32'h12345678, 5, 0, 1, 1, 0, 0, 0, 0, 0, 1};
      vt[2]  = '{1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 0, 1, 5, 32'h12345678, 0};
      vt[3]  = '{1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1, 0, 0, 5, 32'h12345678, 0};
      vt[4]  = '{1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0, 5, 32'h12345678, 0};
      vt[5]  = '{1, 1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 3, 0, 1, 1, 0, 0, 0, 5, 32'h12345678, 2};
      vt[6]  = '{1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0, 1, 3, 32'hAAAA, 1};
      vt[7]  = '{1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0, 1, 3, 32'hBBBB, 0};
      vt[8]  = '{1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0, 0, 3, 32'hBBBB, 0};
      vt[9]  = '{1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0, 3, 32'hBBBB, 0};
      vt[10] = '{1, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 1, 1, 0, 0, 0, 3, 32'hBBBB, 0};
      vt[11] = '{1, 1, 0, 1, 1, 9, 32'h99, 9, 0, 1, 1, 0, 0, 0, 3, 32'hBBBB, 1};
      vt[12] = '{1, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 1, 0, 1, 9, 32'h99, 0};
      vt[13] = '{1, 0, 0, 0, 0, 0, 0, 9, 9, 1, 1, 1, 1, 0, 9, 32'h99, 0};

      drive(0, 0, 0, 0, 0, 0);
      b4.chk_addr1 = '0; b4.chk_addr2 = '0;
      b2.mem_valid = 0; b2.mem_waddr = '0; b2.mem_wdata = '0;
      b2.alu_valid = 0; b2.alu_waddr = '0; b2.alu_wdata = '0;
      b2.chk_addr1 = '0; b2.chk_addr2 = '0;
      rdy = 1'b1;
      #12;
      chk("reset_we", 32'(b4.we), 0);
      chk("reset_count", 32'(b4.count), 0);
      chk("reset_waddr", 32'(b4.waddr), 0);
      chk("reset_wdata", b4.wdata, 0);
      #1 rst = 1'b1;
      #1;
      chk("release_mem_ready", 32'(b4.mem_ready), 1);
      chk("release_alu_ready", 32'(b4.alu_ready), 1);
      tick();

      for (int i = 0; i < 14; i++) begin
         rdy = vt[i].rdy;
         drive(vt[i].mv, vt[i].ma, vt[i].md, vt[i].av, vt[i].aa, vt[i].ad);
         b4.chk_addr1 = vt[i].c1; b4.chk_addr2 = vt[i].c2;
         #1;
         chk($sformatf("v%0d_mem_ready", i), 32'(b4.mem_ready), 32'(vt[i].mr));
         chk($sformatf("v%0d_alu_ready", i), 32'(b4.alu_ready), 32'(vt[i].ar));
         chk($sformatf("v%0d_hit1", i), 32'(b4.chk_hit1), 32'(vt[i].h1));
         chk($sformatf("v%0d_hit2", i), 32'(b4.chk_hit2), 32'(vt[i].h2));
         tick();
         chk($sformatf("v%0d_we", i), 32'(b4.we), 32'(vt[i].we));
         chk($sformatf("v%0d_waddr", i), 32'(b4.waddr), 32'(vt[i].wa));
         chk($sformatf("v%0d_wdata", i), b4.wdata, vt[i].wd);
         chk($sformatf("v%0d_count", i), 32'(b4.count), 32'(vt[i].cnt));
      end

      // Fill: two offers per cycle against one pop per cycle, tracked by a scoreboard.
      b4.chk_addr1 = '0; b4.chk_addr2 = '0;
      for (int k = 0; k < 6; k++) begin
         drive(1, 5'(1 + k), 32'h1000 + k, 1, 5'(10 + k), 32'h2000 + k);
         #1;
         chk($sformatf("fill%0d_mem_ready", k), 32'(b4.mem_ready), 1);
         chk($sformatf("fill%0d_alu_ready", k), 32'(b4.alu_ready), 32'(exp_ar[k]));
         m_acc = b4.mem_ready;
         a_acc = b4.alu_ready;
         if (m_acc) sb.push_back({b4.mem_waddr, b4.mem_wdata});
         if (a_acc) sb.push_back({b4.alu_waddr, b4.alu_wdata});
         tick();
         if (b4.we) port_write();
         chk($sformatf("fill%0d_count", k), 32'(b4.count), 32'(exp_cnt[k]));
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10 && (b4.count != 0 || b4.we); k++) begin
         tick();
         if (b4.we) port_write();
      end
      chk("fill_drained_count", 32'(b4.count), 0);
      chk("fill_scoreboard_empty", 32'(sb.size()), 0);
      chk("fill_write_total", 32'(writes), 8);

      // Pause while a write is on the port.
      drive(1, 7, 32'h77, 1, 8, 32'h88);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("pause_pre_we", 32'(b4.we), 1);
      chk("pause_pre_waddr", 32'(b4.waddr), 7);
      rdy = 1'b0;
      drive(1, 10, 32'hAA, 1, 11, 32'hBB);
      b4.chk_addr1 = 10;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("pause_mem_ready", 32'(b4.mem_ready), 0);
         chk("pause_alu_ready", 32'(b4.alu_ready), 0);
         chk("pause_hit_unaccepted", 32'(b4.chk_hit1), 0);
         tick();
         chk("pause_we", 32'(b4.we), 1);
         chk("pause_waddr", 32'(b4.waddr), 7);
         chk("pause_wdata", b4.wdata, 32'h77);
         chk("pause_count", 32'(b4.count), 1);
      end
      drive(0, 0, 0, 0, 0, 0);
      rdy = 1'b1;
      tick();
      chk("resume_we", 32'(b4.we), 1);
      chk("resume_waddr", 32'(b4.waddr), 8);
      chk("resume_wdata", b4.wdata, 32'h88);
      chk("resume_count", 32'(b4.count), 0);
      tick();
      chk("resume_idle_we", 32'(b4.we), 0);

      // Asynchronous reset with three entries queued and a write on the port.
      drive(1, 1, 32'h11, 1, 2, 32'h22);
      tick();
      drive(1, 4, 32'h44, 1, 6, 32'h66);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("areset_pre_count", 32'(b4.count), 3);
      chk("areset_pre_we", 32'(b4.we), 1);
      b4.chk_addr1 = 2;
      #2 rst = 1'b0;
      #1;
      chk("areset_we", 32'(b4.we), 0);
      chk("areset_count", 32'(b4.count), 0);
      chk("areset_hit_cleared", 32'(b4.chk_hit1), 0);
      #2 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("areset_no_stale_we", 32'(b4.we), 0);
         chk("areset_no_stale_count", 32'(b4.count), 0);
      end

      // Shallow instance: the full condition is reachable in one edge.
      b2.mem_valid = 1; b2.mem_waddr = 1; b2.mem_wdata = 32'h5;
      b2.alu_valid = 1; b2.alu_waddr = 2; b2.alu_wdata = 32'h6;
      #1;
      chk("d2_empty_mem_ready", 32'(b2.mem_ready), 1);
      chk("d2_empty_alu_ready", 32'(b2.alu_ready), 1);
      tick();
      chk("d2_full_count", 32'(b2.count), 2);
      chk("d2_full_mem_ready", 32'(b2.mem_ready), 0);
      chk("d2_full_alu_ready", 32'(b2.alu_ready), 0);
      tick();
      chk("d2_pop_count", 32'(b2.count), 1);
      chk("d2_pop_waddr", 32'(b2.waddr), 1);
      chk("d2_one_mem_ready", 32'(b2.mem_ready), 1);
      chk("d2_one_alu_ready", 32'(b2.alu_ready), 0);
      b2.mem_valid = 0; b2.alu_valid = 0;

      chk("x0_never_written", 32'(x0_writes), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
